centipede_rom_loader: RTL and testbench
=======================================

CENTIPEDE_ROM_LOADER -- requirements
Module: centipede_rom_loader

Interface
REQ-001 The block SHALL have exactly one clock domain, clk_sys; reset is synchronous and active-high, sampled on the rising edge of clk_sys.
REQ-002 SHALL have port: clk_sys  input  1  system clock (12 MHz core clock).
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: ioctl_download  input  1  high for the duration of a ROM download.
REQ-005 SHALL have port: ioctl_wr  input  1  single-cycle byte strobe from the loader.
REQ-006 SHALL have port: ioctl_addr  input  25  byte address within the download image.
REQ-007 SHALL have port: ioctl_dout  input  8  download data byte.
REQ-008 SHALL have port: ioctl_index  input  8  image index; only index 0 is accepted.
REQ-009 SHALL have port: ioctl_wait  output  1  back-pressure to the loader; high while a write is outstanding.
REQ-010 SHALL have port: rom_we  output  1  write request to the target ROM RAMs.
REQ-011 SHALL have port: rom_ack  input  1  target accepted the write.
REQ-012 SHALL have port: rom_sel  output  2  region: 0 = program ROM, 1 = playfield gfx, 2 = motion-object gfx.
REQ-013 SHALL have port: rom_addr  output  13  address within the selected region.
REQ-014 SHALL have port: rom_data  output  8  byte to write.
REQ-015 SHALL have port: busy  output  1  high in LOAD or WRITE state.
REQ-016 SHALL have port: done  output  1  image loaded completely and without error.
REQ-017 SHALL have port: err  output  1  sticky error flag for the current download.
REQ-018 SHALL have port: checksum  output  8  mod-256 sum of all accepted bytes.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, WRITE, FINISH.
REQ-020 A rising edge of ioctl_download (registered previous value 0, current value 1) SHALL, in any state, clear byte count, checksum, done and err, and move to LOAD.
REQ-021 Address map: 0x0000-0x1FFF -> rom_sel=0, rom_addr=ioctl_addr[12:0]; 0x2000-0x27FF -> rom_sel=1, rom_addr={2'b00,ioctl_addr[10:0]}; 0x2800-0x2FFF -> rom_sel=2, rom_addr={2'b00,ioctl_addr[10:0]}.
REQ-022 In LOAD, ioctl_wr=1 with ioctl_index=0 and ioctl_addr<0x3000 SHALL latch sel/addr/data and, at the next edge, assert rom_we=1 and ioctl_wait=1 and enter WRITE.
REQ-023 In LOAD, ioctl_wr=1 with ioctl_addr>=0x3000 SHALL be dropped (no rom_we) and set err=1.
REQ-024 In LOAD, ioctl_wr=1 with ioctl_index!=0 SHALL be ignored silently.
REQ-025 rom_sel/rom_addr/rom_data SHALL hold stable while rom_we=1.
REQ-026 In WRITE, rom_ack sampled high SHALL drop rom_we and ioctl_wait at the next edge, increment the 14-bit byte count, add rom_data to checksum (mod 256), and return to LOAD.
REQ-027 rom_we SHALL be high for at least one cycle; rom_ack is ignored outside WRITE.
REQ-028 ioctl_wr=1 during WRITE is a protocol violation: the byte SHALL be dropped and err set=1; the outstanding write continues.
REQ-029 ioctl_download falling SHALL move LOAD to FINISH; if it falls during WRITE, the write SHALL complete first, then FINISH.
REQ-030 In FINISH (one cycle): done=1 if count==12288 and err==0, else err=1; then IDLE.
REQ-031 done and err SHALL hold in IDLE until the next download rising edge or reset.
REQ-032 busy SHALL equal 1 exactly in LOAD and WRITE.

Reset
REQ-033 When reset=1 at an edge, all outputs SHALL be 0 at the next edge (ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, busy, done, err, checksum), the count SHALL be 0, and the state SHALL be IDLE, including mid-WRITE (the write is abandoned).
REQ-034 The download edge detector SHALL be reset to 0, so a download held high through reset starts a fresh LOAD on the first edge after release.

Verification
REQ-035 Full image: 12288 sequential bytes 0x00..0x2FFF, data=addr[7:0], rom_ack 1 cycle after rom_we -> done=1, err=0, checksum=0x00, 12288 rom_we pulses.
REQ-036 Region split: write addr 0x2801 data 0x5A -> rom_sel=2, rom_addr=0x0001, rom_data=0x5A, ioctl_wait high until the cycle after rom_ack.
REQ-037 Stalled ack: rom_ack delayed 5 cycles -> rom_we and ioctl_wait high for exactly 6 cycles with outputs stable; 2nd ioctl_wr during the stall -> dropped, err=1.
REQ-038 Short image: 100 bytes, then download falls -> err=1, done=0, count 100.
REQ-039 Out of range: addr 0x3000 -> no rom_we, err=1; index=1 write -> no rom_we, err unchanged.
REQ-040 Reset mid-WRITE: reset asserted with rom_we=1 -> next edge rom_we=0, ioctl_wait=0, busy=0; download still high after release -> LOAD with count=0.

Source files
------------

// File: rtl/centipede_rom_loader.sv
// rtl/centipede_rom_loader.sv - routes a 12 KB Centipede ROM download into program/playfield/motion-object ROM RAMs
//
// Ports:
//   clk_sys        in   1   system clock
//   reset          in   1   synchronous active-high reset
//   ioctl_download in   1   high for the duration of a ROM download
//   ioctl_wr       in   1   single-cycle byte strobe from the loader
//   ioctl_addr     in  25   byte address within the download image
//   ioctl_dout     in   8   download data byte
//   ioctl_index    in   8   image index (only 0 is loaded)
//   ioctl_wait     out  1   back-pressure while a ROM write is outstanding
//   rom_we         out  1   write request to the target ROM RAMs
//   rom_ack        in   1   target accepted the write
//   rom_sel        out  2   0 = program, 1 = playfield gfx, 2 = motion-object gfx
//   rom_addr       out 13   address within the selected region
//   rom_data       out  8   byte to write
//   busy           out  1   high in LOAD or WRITE
//   done           out  1   complete, error-free image loaded
//   err            out  1   sticky error flag for the current download
//   checksum       out  8   mod-256 sum of all accepted bytes

module centipede_rom_loader (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        rom_we,
    input  logic        rom_ack,
    output logic [1:0]  rom_sel,
    output logic [12:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  checksum
);

    localparam logic [24:0] IMAGE_END  = 25'h3000;
    localparam logic [24:0] PF_BASE    = 25'h2000;
    localparam logic [24:0] MO_BASE    = 25'h2800;
    localparam logic [13:0] IMAGE_SIZE = 14'd12288;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state, state_d;
    logic        dl_prev;
    logic [13:0] byte_count, byte_count_d;
    logic [7:0]  checksum_d;
    logic        done_d, err_d;
    logic        rom_we_d, ioctl_wait_d;
    logic [1:0]  rom_sel_d;
    logic [12:0] rom_addr_d;
    logic [7:0]  rom_data_d;
    logic        dl_rise;

    assign dl_rise = ioctl_download && !dl_prev;
    assign busy    = (state == LOAD) || (state == WRITE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_prev    <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            rom_we     <= 1'b0;
            ioctl_wait <= 1'b0;
            rom_sel    <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
        end else begin
            state      <= state_d;
            dl_prev    <= ioctl_download;
            byte_count <= byte_count_d;
            checksum   <= checksum_d;
            done       <= done_d;
            err        <= err_d;
            rom_we     <= rom_we_d;
            ioctl_wait <= ioctl_wait_d;
            rom_sel    <= rom_sel_d;
            rom_addr   <= rom_addr_d;
            rom_data   <= rom_data_d;
        end
    end

    always_comb begin
        state_d      = state;
        byte_count_d = byte_count;
        checksum_d   = checksum;
        done_d       = done;
        err_d        = err;
        rom_we_d     = rom_we;
        ioctl_wait_d = ioctl_wait;
        rom_sel_d    = rom_sel;
        rom_addr_d   = rom_addr;
        rom_data_d   = rom_data;

        if (dl_rise) begin
            // A new download restarts everything, abandoning any write in flight.
            state_d      = LOAD;
            byte_count_d = '0;
            checksum_d   = '0;
            done_d       = 1'b0;
            err_d        = 1'b0;
            rom_we_d     = 1'b0;
            ioctl_wait_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end

                LOAD: begin
                    if (!ioctl_download) begin
                        state_d = FINISH;
                    end else if (ioctl_wr && (ioctl_index == 8'd0)) begin
                        if (ioctl_addr < IMAGE_END) begin
                            if (ioctl_addr < PF_BASE) begin
                                rom_sel_d  = 2'd0;
                                rom_addr_d = ioctl_addr[12:0];
                            end else if (ioctl_addr < MO_BASE) begin
                                rom_sel_d  = 2'd1;
                                rom_addr_d = {2'b00, ioctl_addr[10:0]};
                            end else begin
                                rom_sel_d  = 2'd2;
                                rom_addr_d = {2'b00, ioctl_addr[10:0]};
                            end
                            rom_data_d   = ioctl_dout;
                            rom_we_d     = 1'b1;
                            ioctl_wait_d = 1'b1;
                            state_d      = WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                WRITE: begin
                    // A strobe here means the loader ignored ioctl_wait; the
                    // byte is lost, so flag it while the current write finishes.
                    if (ioctl_wr) begin
                        err_d = 1'b1;
                    end
                    if (rom_ack) begin
                        rom_we_d     = 1'b0;
                        ioctl_wait_d = 1'b0;
                        byte_count_d = byte_count + 14'd1;
                        checksum_d   = checksum + rom_data;
                        state_d      = ioctl_download ? LOAD : FINISH;
                    end
                end

                FINISH: begin
                    if ((byte_count == IMAGE_SIZE) && !err) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_centipede_rom_loader.sv
// tb/tb_centipede_rom_loader.sv - directed self-checking bench for centipede_rom_loader

module tb_centipede_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic        rom_we;
    logic        rom_ack = 1'b0;
    logic [1:0]  rom_sel;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  checksum;

    int errors = 0;
    int checks = 0;
    int we_pulses = 0;
    logic we_seen = 1'b0;

    centipede_rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .rom_we         (rom_we),
        .rom_ack        (rom_ack),
        .rom_sel        (rom_sel),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .checksum       (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (rom_we && !we_seen) we_pulses = we_pulses + 1;
        we_seen = rom_we;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input int delay);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        repeat (delay) tick();
        rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
    endtask

    initial begin
        int pulses0;
        int highcnt;
        logic stable;

        // Reset state
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_we", rom_we, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_csum", checksum, 0);
        chk("rst_outs", {rom_sel, rom_addr, rom_data}, 0);

        // Full image, data = addr[7:0], ack one cycle after rom_we
        ioctl_download = 1'b1;
        tick();
        chk("full_busy", busy, 1);
        pulses0 = we_pulses;
        for (int i = 0; i < 12288; i++) begin
            write_byte(25'(i), 8'(i), 0);
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("full_done", done, 1);
        chk("full_err", err, 0);
        chk("full_csum", checksum, 8'h00);
        chk("full_count", dut.byte_count, 12288);
        chk("full_pulses", we_pulses - pulses0, 12288);
        chk("full_idle_busy", busy, 0);
        repeat (3) tick();
        chk("full_done_hold", done, 1);

        // Region mapping
        ioctl_download = 1'b1;
        tick();
        chk("dl2_done_clr", done, 0);
        ioctl_addr = 25'h2801; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("mo_we", rom_we, 1);
        chk("mo_wait", ioctl_wait, 1);
        chk("mo_sel", rom_sel, 2);
        chk("mo_addr", rom_addr, 13'h0001);
        chk("mo_data", rom_data, 8'h5A);
        tick();
        chk("mo_wait_noack", ioctl_wait, 1);
        rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
        chk("mo_we_drop", rom_we, 0);
        chk("mo_wait_drop", ioctl_wait, 0);
        ioctl_addr = 25'h2123; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("pf_sel_addr", {rom_sel, rom_addr}, {2'd1, 13'h0123});
        rom_ack = 1'b1; tick(); rom_ack = 1'b0;
        ioctl_addr = 25'h1ABC; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("prog_sel_addr", {rom_sel, rom_addr}, {2'd0, 13'h1ABC});
        rom_ack = 1'b1; tick(); rom_ack = 1'b0;
        chk("three_csum", checksum, 8'h8D);

        // Stalled ack with a second strobe during the stall
        pulses0 = we_pulses;
        ioctl_addr = 25'h0005; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        highcnt = rom_we ? 1 : 0;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                ioctl_addr = 25'h0010; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;
            end
            tick();
            ioctl_wr = 1'b0;
            if (rom_we) highcnt++;
            if (!ioctl_wait || rom_sel !== 2'd0 || rom_addr !== 13'h0005 || rom_data !== 8'h77)
                stable = 1'b0;
        end
        rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
        if (rom_we) highcnt++;
        chk("stall_we_cycles", highcnt, 6);
        chk("stall_stable", stable, 1);
        chk("stall_err", err, 1);
        tick();
        chk("stall_no_replay", rom_we, 0);
        chk("stall_pulses", we_pulses - pulses0, 1);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("stall_fin_done", done, 0);
        chk("stall_fin_err", err, 1);

        // Short image
        ioctl_download = 1'b1;
        tick();
        chk("short_err_clr", err, 0);
        for (int i = 0; i < 100; i++) begin
            write_byte(25'(i), 8'(i), 0);
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("short_err", err, 1);
        chk("short_done", done, 0);
        chk("short_count", dut.byte_count, 100);
        chk("short_csum", checksum, 8'h56);

        // Out of range and foreign index
        ioctl_download = 1'b1;
        tick();
        pulses0 = we_pulses;
        ioctl_index = 8'd1; ioctl_addr = 25'h0010; ioctl_dout = 8'h33; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0; ioctl_index = 8'd0;
        chk("idx1_we", rom_we, 0);
        chk("idx1_err", err, 0);
        ioctl_addr = 25'h3000; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("oor_we", rom_we, 0);
        chk("oor_err", err, 1);
        tick();
        chk("oor_pulses", we_pulses - pulses0, 0);
        chk("oor_busy", busy, 1);

        // Reset in the middle of a write, download held high throughout
        ioctl_addr = 25'h0000; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("mid_we", rom_we, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_we", rom_we, 0);
        chk("mid_rst_wait", ioctl_wait, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_count", dut.byte_count, 0);
        reset = 1'b0;
        tick();
        chk("mid_rel_busy", busy, 1);
        chk("mid_rel_count", dut.byte_count, 0);
        write_byte(25'h0002, 8'h09, 0);
        chk("mid_rel_csum", checksum, 8'h09);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
